// File: rtl/axis_frame_packer.sv
// AXI-Stream frame packer: cuts an input stream into fixed-length frames and marks the last beat.
// A flush pads the open frame with PAD_VALUE beats. The output path is a registered 2-entry skid buffer.
module axis_frame_packer #(
   parameter int unsigned       DATA_W    = 32,
   parameter int unsigned       LEN_W     = 16,
   parameter logic [DATA_W-1:0] PAD_VALUE = '0
) (
   input  logic              axi_clk,
   input  logic              axi_rst,
   input  logic [DATA_W-1:0] s_axis_data,
   input  logic              s_axis_valid,
   output logic              s_axis_ready,
   output logic [DATA_W-1:0] m_axis_data,
   output logic              m_axis_valid,
   output logic              m_axis_last,
   input  logic              m_axis_ready,
   input  logic [LEN_W-1:0]  i_frame_len,
   input  logic              i_flush,
   output logic              o_intr
);

   typedef enum logic [1:0] {StIdle, StRun, StPad} state_e;

   state_e            state_q, state_d;
   logic [LEN_W-1:0]  len_q, len_d, cnt_q, cnt_d, len_cur;
   logic              out_valid_q, out_valid_d, out_last_q, out_last_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              skid_valid_q, skid_valid_d, skid_last_q, skid_last_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic              ready_q, ready_d, intr_q, intr_d;
   logic              in_fire, pad_fire, load, load_last;
   logic [DATA_W-1:0] load_data;

   // ready_q is held low in PAD, so a real beat and a pad beat never load together
   assign in_fire   = s_axis_valid & ready_q;
   assign pad_fire  = (state_q == StPad) & ~skid_valid_q;
   assign load      = in_fire | pad_fire;
   assign load_data = pad_fire ? PAD_VALUE : s_axis_data;

   // In IDLE the frame has not started yet, so the length comes straight from the input
   always_comb begin
      len_cur = len_q;
      if (state_q == StIdle) begin
         len_cur = (i_frame_len == '0) ? LEN_W'(1) : i_frame_len;
      end
   end

   assign load_last = (cnt_q == len_cur - LEN_W'(1));

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      if (load) begin
         cnt_d = load_last ? '0 : cnt_q + LEN_W'(1);
         if (state_q == StIdle) len_d = len_cur;
      end
      case (state_q)
         StIdle: if (load && !load_last) state_d = StRun;
         StRun: begin
            // A last real beat wins over a coincident flush: the frame is already complete
            if (load && load_last) state_d = StIdle;
            else if (i_flush)      state_d = StPad;
         end
         StPad:   if (load && load_last) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_last_d   = out_last_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      skid_last_d  = skid_last_q;
      if (skid_valid_q) begin
         if (m_axis_ready) begin
            out_data_d   = skid_data_q;
            out_last_d   = skid_last_q;
            skid_valid_d = 1'b0;
         end
      end else if (load) begin
         if (!out_valid_q || m_axis_ready) begin
            out_valid_d = 1'b1;
            out_data_d  = load_data;
            out_last_d  = load_last;
         end else begin
            skid_valid_d = 1'b1;
            skid_data_d  = load_data;
            skid_last_d  = load_last;
         end
      end else if (m_axis_ready) begin
         out_valid_d = 1'b0;
      end
      ready_d = ~skid_valid_d & (state_d != StPad);
      intr_d  = out_valid_q & m_axis_ready & out_last_q;
   end

   always_ff @(posedge axi_clk or negedge axi_rst) begin
      if (!axi_rst) begin
         state_q      <= StIdle;
         len_q        <= LEN_W'(1);
         cnt_q        <= '0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_last_q   <= 1'b0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         skid_last_q  <= 1'b0;
         ready_q      <= 1'b0;
         intr_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         cnt_q        <= cnt_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_last_q   <= out_last_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         skid_last_q  <= skid_last_d;
         ready_q      <= ready_d;
         intr_q       <= intr_d;
      end
   end

   assign s_axis_ready = ready_q;
   assign m_axis_data  = out_data_q;
   assign m_axis_valid = out_valid_q;
   assign m_axis_last  = out_last_q;
   assign o_intr       = intr_q;

endmodule

// File: tb/tb_axis_frame_packer.sv
// Bench for axis_frame_packer: frame-level queue model checked every cycle plus directed scenarios
// with literal expected beat sequences.
module tb_axis_frame_packer;
   localparam int DW = 32;
   localparam int LW = 16;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   logic          axi_clk = 1'b0;
   logic          axi_rst = 1'b0;
   logic [DW-1:0] s_axis_data = '0;
   logic          s_axis_valid = 1'b0;
   logic          s_axis_ready;
   logic [DW-1:0] m_axis_data;
   logic          m_axis_valid;
   logic          m_axis_last;
   logic          m_axis_ready = 1'b0;
   logic [LW-1:0] i_frame_len = 16'd4;
   logic          i_flush = 1'b0;
   logic          o_intr;

   axis_frame_packer #(
      .DATA_W   (DW),
      .LEN_W    (LW),
      .PAD_VALUE(32'h0)
   ) dut (
      .axi_clk     (axi_clk),
      .axi_rst     (axi_rst),
      .s_axis_data (s_axis_data),
      .s_axis_valid(s_axis_valid),
      .s_axis_ready(s_axis_ready),
      .m_axis_data (m_axis_data),
      .m_axis_valid(m_axis_valid),
      .m_axis_last (m_axis_last),
      .m_axis_ready(m_axis_ready),
      .i_frame_len (i_frame_len),
      .i_flush     (i_flush),
      .o_intr      (o_intr)
   );

   always #5 axi_clk = ~axi_clk;

   int    n_chk = 0;
   int    n_pass = 0;
   beat_t exp_q[$];
   beat_t log_q[$];
   int    log_cyc[$];
   int    cyc = 0;
   int    intr_cnt = 0;
   bit    chk_ready_en = 1'b0;

   // Frame model state: is a frame open, its length, beats produced so far
   bit            mopen = 1'b0;
   int            mlen = 1;
   int            mcnt = 0;
   bit            prev_stall = 1'b0;
   logic [DW-1:0] prev_data = '0;
   logic          prev_last = 1'b0;
   logic          exp_intr = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
   endtask

   // Sampled on the falling edge: what is seen here is what the next rising edge will use
   always @(negedge axi_clk) begin
      beat_t b;
      bit    open_before;
      if (!axi_rst) begin
         exp_q.delete();
         mopen      = 1'b0;
         mcnt       = 0;
         prev_stall = 1'b0;
         exp_intr   = 1'b0;
      end else begin
         cyc++;
         chk("o_intr", o_intr, exp_intr);
         if (o_intr) intr_cnt++;
         if (prev_stall) begin
            chk("stall_valid_hold", m_axis_valid, 1'b1);
            chk("stall_data_hold", m_axis_data, prev_data);
            chk("stall_last_hold", m_axis_last, prev_last);
         end
         if (chk_ready_en && !s_axis_ready) chk("ready_low_only_when_full", m_axis_valid, 1'b1);
         exp_intr = 1'b0;
         if (m_axis_valid && m_axis_ready) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               $display("FAIL out_beat: got data %0h last %0b, required no beat", m_axis_data,
                        m_axis_last);
            end else begin
               b = exp_q.pop_front();
               chk("m_axis_data", m_axis_data, b.data);
               chk("m_axis_last", m_axis_last, b.last);
               exp_intr = b.last;
            end
            log_q.push_back({m_axis_data, m_axis_last});
            log_cyc.push_back(cyc);
         end
         prev_stall  = m_axis_valid && !m_axis_ready;
         prev_data   = m_axis_data;
         prev_last   = m_axis_last;
         open_before = mopen;
         if (s_axis_valid && s_axis_ready) begin
            if (!mopen) begin
               mlen  = (i_frame_len == '0) ? 1 : int'(i_frame_len);
               mcnt  = 0;
               mopen = 1'b1;
            end
            mcnt++;
            b.data = s_axis_data;
            b.last = (mcnt == mlen);
            exp_q.push_back(b);
            if (b.last) mopen = 1'b0;
         end
         if (i_flush && open_before && mopen) begin
            while (mcnt < mlen) begin
               mcnt++;
               b.data = '0;
               b.last = (mcnt == mlen);
               exp_q.push_back(b);
            end
            mopen = 1'b0;
         end
      end
   end

   task automatic send(input logic [DW-1:0] d);
      bit hs;
      int t;
      s_axis_data  = d;
      s_axis_valid = 1'b1;
      t = 0;
      hs = 1'b0;
      do begin
         @(negedge axi_clk);
         hs = s_axis_ready;
         t++;
         @(posedge axi_clk);
         #1;
      end while (!hs && t < 50);
      if (!hs) begin
         n_chk++;
         $display("FAIL send_timeout: beat %0h not accepted, s_axis_ready 0, required 1", d);
      end
   endtask

   task automatic drain(input string tag);
      s_axis_valid = 1'b0;
      m_axis_ready = 1'b1;
      repeat (8) @(posedge axi_clk);
      #1;
      chk({tag, "_drained"}, exp_q.size(), 0);
   endtask

   initial begin
      int  base;
      int  ib;
      int  idx;
      bit  pend;
      bit  hs;
      #2;
      chk("rst_m_valid", m_axis_valid, 1'b0);
      chk("rst_m_last", m_axis_last, 1'b0);
      chk("rst_m_data", m_axis_data, 0);
      chk("rst_o_intr", o_intr, 1'b0);
      chk("rst_s_ready", s_axis_ready, 1'b0);
      @(posedge axi_clk);
      #1;
      axi_rst = 1'b1;
      chk("ready_before_first_edge", s_axis_ready, 1'b0);
      @(posedge axi_clk);
      #1;
      chk("ready_after_first_edge", s_axis_ready, 1'b1);

      // Two back-to-back 4-beat frames
      base = log_q.size();
      ib = intr_cnt;
      i_frame_len = 16'd4;
      m_axis_ready = 1'b1;
      for (int i = 1; i <= 8; i++) send(DW'(i));
      drain("s1");
      chk("s1_beats", log_q.size() - base, 8);
      for (int i = 0; i < 8; i++) begin
         if (base + i < log_q.size()) begin
            chk("s1_data", log_q[base+i].data, i + 1);
            chk("s1_last", log_q[base+i].last, (i == 3 || i == 7));
         end
      end
      if (base + 4 < log_cyc.size()) chk("s1_no_bubble", log_cyc[base+4] - log_cyc[base+3], 1);
      chk("s1_intr_count", intr_cnt - ib, 2);

      // frame_len 3, downstream ready toggling, bursty upstream valid
      i_frame_len = 16'd3;
      chk_ready_en = 1'b1;
      idx = 0;
      pend = 1'b0;
      for (int c = 0; c < 300 && idx < 12; c++) begin
         m_axis_ready = c[0];
         if (!pend && $urandom_range(0, 3) != 0) begin
            s_axis_valid = 1'b1;
            s_axis_data  = 32'h100 + DW'(idx);
            pend = 1'b1;
         end
         @(negedge axi_clk);
         hs = s_axis_valid && s_axis_ready;
         @(posedge axi_clk);
         #1;
         if (hs) begin
            pend = 1'b0;
            idx++;
            s_axis_valid = 1'b0;
         end
      end
      chk("s2_all_sent", idx, 12);
      drain("s2");
      chk_ready_en = 1'b0;

      // Flush after two beats of a 5-beat frame
      base = log_q.size();
      ib = intr_cnt;
      i_frame_len = 16'd5;
      send(32'hA);
      send(32'hB);
      s_axis_valid = 1'b0;
      i_flush = 1'b1;
      @(posedge axi_clk);
      #1;
      i_flush = 1'b0;
      chk("s3_ready_in_pad", s_axis_ready, 1'b0);
      drain("s3");
      chk("s3_beats", log_q.size() - base, 5);
      for (int i = 0; i < 5; i++) begin
         if (base + i < log_q.size()) begin
            chk("s3_data", log_q[base+i].data, (i == 0) ? 32'hA : (i == 1) ? 32'hB : 32'h0);
            chk("s3_last", log_q[base+i].last, (i == 4));
         end
      end
      chk("s3_intr_count", intr_cnt - ib, 1);

      // frame_len 0 behaves as 1
      base = log_q.size();
      ib = intr_cnt;
      i_frame_len = 16'd0;
      for (int i = 0; i < 3; i++) send(32'h21 + DW'(i));
      drain("s4");
      chk("s4_beats", log_q.size() - base, 3);
      for (int i = 0; i < 3; i++) begin
         if (base + i < log_q.size()) begin
            chk("s4_data", log_q[base+i].data, 32'h21 + i);
            chk("s4_last", log_q[base+i].last, 1'b1);
         end
      end
      chk("s4_intr_count", intr_cnt - ib, 3);

      // Reset mid-frame with both buffer entries full
      ib = intr_cnt;
      i_frame_len = 16'd4;
      m_axis_ready = 1'b0;
      send(32'h31);
      send(32'h32);
      s_axis_valid = 1'b0;
      @(posedge axi_clk);
      #1;
      chk("s5_skid_full_ready", s_axis_ready, 1'b0);
      #2;
      axi_rst = 1'b0;
      #1;
      chk("s5_rst_m_valid", m_axis_valid, 1'b0);
      chk("s5_rst_m_data", m_axis_data, 0);
      chk("s5_rst_m_last", m_axis_last, 1'b0);
      chk("s5_rst_s_ready", s_axis_ready, 1'b0);
      @(posedge axi_clk);
      #1;
      axi_rst = 1'b1;
      @(posedge axi_clk);
      #1;
      chk("s5_ready_after_release", s_axis_ready, 1'b1);
      base = log_q.size();
      m_axis_ready = 1'b1;
      for (int i = 0; i < 4; i++) send(32'h41 + DW'(i));
      drain("s5");
      chk("s5_beats", log_q.size() - base, 4);
      for (int i = 0; i < 4; i++) begin
         if (base + i < log_q.size()) begin
            chk("s5_data", log_q[base+i].data, 32'h41 + i);
            chk("s5_last", log_q[base+i].last, (i == 3));
         end
      end
      chk("s5_intr_count", intr_cnt - ib, 1);

      // Flush coinciding with the last real beat, then flush held into IDLE
      base = log_q.size();
      ib = intr_cnt;
      i_frame_len = 16'd4;
      send(32'h51);
      send(32'h52);
      send(32'h53);
      i_flush = 1'b1;
      send(32'h54);
      s_axis_valid = 1'b0;
      @(posedge axi_clk);
      #1;
      i_flush = 1'b0;
      drain("s6");
      chk("s6_beats", log_q.size() - base, 4);
      for (int i = 0; i < 4; i++) begin
         if (base + i < log_q.size()) begin
            chk("s6_data", log_q[base+i].data, 32'h51 + i);
            chk("s6_last", log_q[base+i].last, (i == 3));
         end
      end
      chk("s6_intr_count", intr_cnt - ib, 1);
      chk("s6_ready_idle", s_axis_ready, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/axis_frame_packer.md
AXIS_FRAME_PACKER -- requirements
Module: axis_frame_packer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the stream data width in bits.
REQ-002 SHALL have parameter LEN_W, default 16, meaning the width of the frame-length input.
REQ-003 SHALL have parameter PAD_VALUE, default 0, meaning the data word emitted on padding beats.
REQ-004 SHALL have port axi_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port axi_rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port s_axis_data, input, DATA_W bits: upstream data from the accumulator FIFO output.
REQ-007 SHALL have port s_axis_valid, input, 1 bit: upstream data valid.
REQ-008 SHALL have port s_axis_ready, output, 1 bit: this block accepts a beat.
REQ-009 SHALL have port m_axis_data, output, DATA_W bits: data to the DMA S2MM channel.
REQ-010 SHALL have port m_axis_valid, output, 1 bit: downstream data valid.
REQ-011 SHALL have port m_axis_last, output, 1 bit: final beat of a frame.
REQ-012 SHALL have port m_axis_ready, input, 1 bit: DMA accepts a beat.
REQ-013 SHALL have port i_frame_len, input, LEN_W bits: beats per frame.
REQ-014 SHALL have port i_flush, input, 1 bit: request to close the current frame with padding.
REQ-015 SHALL have port o_intr, output, 1 bit: one-cycle pulse per completed frame.

Function
REQ-016 A beat SHALL transfer on either side only when valid and ready are both high at a rising edge.
REQ-017 The output SHALL be fully registered, with a 2-entry buffer (output register plus skid register).
- s_axis_ready = !skid_full, driven from a register.
- An input beat accepted at edge N SHALL appear on m_axis_data/m_axis_valid after edge N when the output register is empty or draining.
REQ-018 While m_axis_valid=1 and m_axis_ready=0:
- m_axis_data and m_axis_last SHALL hold stable.
- m_axis_valid SHALL NOT deassert.
REQ-019 The FSM SHALL have three states: IDLE, RUN and PAD.
REQ-020 IDLE -> RUN SHALL occur on the first accepted input beat.
- i_frame_len is latched into len_q on that edge.
- len 0 is treated as 1.
- i_frame_len changes mid-frame SHALL have no effect.
REQ-021 A beat counter, LEN_W bits, SHALL count beats loaded into the output path.
- The beat loaded when count == len_q-1 SHALL carry last=1.
- The counter then clears and the FSM returns to IDLE.
REQ-022 i_flush sampled high in RUN SHALL move the FSM to PAD.
- s_axis_ready is forced to 0 in PAD.
- PAD_VALUE beats are generated until the beat with count == len_q-1 (last=1) is loaded.
- The FSM then returns to IDLE.
REQ-023 i_flush in IDLE SHALL be ignored.
REQ-024 If i_flush coincides with acceptance of the frame's last real beat, the frame SHALL close normally and no padding SHALL be emitted.
REQ-025 o_intr SHALL pulse high for exactly one cycle on the edge where a last=1 beat completes its downstream handshake.
REQ-026 Back-to-back frames SHALL be supported with no idle cycle between the last beat of one frame and the first beat of the next.
REQ-027 The counter SHALL never wrap: len_q = 2^LEN_W-1 is the maximum frame size.

Reset
REQ-028 While axi_rst=0, asynchronously:
- FSM = IDLE; counter = 0; len_q = 1.
- Both buffer entries are empty.
- m_axis_valid = 0, m_axis_last = 0, m_axis_data = 0, o_intr = 0.
- s_axis_ready = 0.
REQ-029 s_axis_ready SHALL rise on the first edge after axi_rst deasserts.
REQ-030 Reset mid-frame SHALL discard all buffered beats and the partial frame; no o_intr SHALL be issued for that frame.

Verification
REQ-031 Scenario: frame_len=4, continuous valid, m_axis_ready=1, data 1..8 -> two frames, each 4 beats; last on data 4 and 8; o_intr pulses twice; no bubble between the frames.
REQ-032 Scenario: frame_len=3, m_axis_ready toggling 1/0 each cycle, random s_axis_valid -> output sequence matches input order; data and last are stable during stalls; s_axis_ready deasserts only when the skid entry is full.
REQ-033 Scenario: frame_len=5, two beats (0xA, 0xB) then i_flush pulse -> output is A, B, 0, 0, 0 with last on the fifth beat; one o_intr pulse; input is stalled during PAD.
REQ-034 Scenario: frame_len=0 -> every beat is emitted with last=1 and o_intr pulses once per beat.
REQ-035 Scenario: axi_rst asserted after 2 of 4 beats with m_axis_ready=0 -> outputs clear immediately; after release, a new 4-beat frame starts at count 0 with no stale data.
REQ-036 Scenario: i_flush asserted on the same edge as the 4th beat of a frame_len=4 frame -> frame closes with 4 real beats and no padding beats.
